vec_strobe_sequencer: RTL
=========================

// Module: vec_strobe_sequencer
// PURPOSE
//  Shares one WIDTH-lane data/strobe bus among NREQ requesters and sequences each transfer.
//  Drives d_out, waits SETUP_CYC cycles, pulses strb_out for PULSE_CYC cycles, then holds d_out HOLD_CYC cycles.
//  This guarantees by construction the posedge/negedge $setup windows that the downstream timing-checked capture cells enforce.
//  Sits between the requesters and the vector-clocked capture block.
// PARAMETERS
//  WIDTH      3   lanes on the data/strobe bus
//  NREQ       2   number of requesters (>=1)
//  SETUP_CYC  10  cycles d_out is stable before strb_out rises (>=1)
//  PULSE_CYC  2   cycles strb_out is high (>=1)
//  HOLD_CYC   1   cycles d_out is held after strb_out falls (>=0; 0 skips HOLD)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  req        in   NREQ        level request per requester; may drop before grant
//  req_data   in   NREQ*WIDTH  data word, requester i at [i*WIDTH +: WIDTH]
//  req_mask   in   NREQ*WIDTH  lanes to update/strobe, same packing as req_data
//  flush      in   1           synchronous abort, highest priority
//  gnt        out  NREQ        one-hot 1-cycle pulse: request accepted, data/mask sampled
//  done       out  NREQ        one-hot 1-cycle pulse: transfer complete
//  aborted    out  1           1-cycle pulse: transfer killed by flush
//  busy       out  1           high whenever state != IDLE
//  d_out      out  WIDTH       data bus to capture block
//  strb_out   out  WIDTH       per-lane strobe ("clk" vector) to capture block
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; d_out, strb_out, gnt, done, aborted, busy = 0; rr pointer = 0.
//    Reset applies immediately, with no clock edge required.
//  - FSM states: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
//    PULSE goes directly to IDLE when HOLD_CYC = 0.
//  - IDLE, any req high at edge E: round-robin grant starting at the rr pointer.
//    gnt[i] is high for the cycle after E.
//    d_out <= (d_out & ~mask) | (data & mask); unmasked lanes keep their value.
//    rr pointer <= i+1 mod NREQ; state -> SETUP.
//  - SETUP: down-counter runs for exactly SETUP_CYC cycles.
//    strb_out <= mask at E+SETUP_CYC; state -> PULSE.
//  - PULSE: strb_out = latched mask for PULSE_CYC cycles; strb_out <= 0 at E+SETUP_CYC+PULSE_CYC.
//  - HOLD: d_out unchanged for HOLD_CYC cycles.
//    done[i] is high for the cycle after E+SETUP_CYC+PULSE_CYC+HOLD_CYC; state -> IDLE.
//  - Back-to-back: the next grant is taken on the first edge at which state is IDLE.
//    So the gap between grants is SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles.
//  - Zero mask: accepted and sequenced normally; d_out and strb_out stay unchanged, done still pulses.
//  - Unmasked lanes: strb_out stays 0 and d_out is constant for the whole transfer.
//  - flush at any non-IDLE edge:
//    state -> IDLE and strb_out <= 0 next cycle; d_out is retained.
//    aborted pulses; no done; the rr pointer keeps its post-grant value.
//  - flush in IDLE: no effect, and no grant on that edge.
//  - req changes after grant: ignored; data and mask are latched at grant.
//  - Counter width: $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1). The counter never wraps.
//  - All outputs are registered.
// STRUCTURE
//  - Package vec_strobe_pkg: state enum (IDLE, SETUP, PULSE, HOLD), default timing constants,
//    and a counter-width function.
//  - Sub-module rr_arbiter #(NREQ): req, advance, pointer in; one-hot grant out.
//  - The top level holds the FSM, counter, latched mask/requester index and output registers.
// TESTING
//  1. Defaults, d_out=000, req0 data=011 mask=111 granted at E:
//     gnt0 at E+1; d_out=011; strb_out=111 during E+10..E+11; done0 at E+13.
//  2. req0 and req1 both high, pointer 0: gnt0 at E, gnt1 at E+14.
//     A third grant returns to req0 (round-robin).
//  3. d_out=111, req1 data=000 mask=100: d_out=011; strb_out=100 only; lanes 0-1 never strobe.
//  4. flush in 2nd PULSE cycle: strb_out=000 next cycle; aborted=1 for one cycle.
//     No done1; the next request completes with full timing.
//  5. rst_n low mid-SETUP with no clock: all outputs 0 at once.
//     After release, a held req is re-granted and waits a full SETUP_CYC.
//  6. SETUP_CYC=1, PULSE_CYC=1, HOLD_CYC=0: strobe at E+1 for 1 cycle, done at E+2.
//     Grants are 3 cycles apart; a checker asserts d_out stable for SETUP_CYC cycles before every strb_out rise.

Source files
------------

// File: rtl/vec_strobe_pkg.sv
// Shared types and sizing helpers for the strobe sequencer and its arbiter.
// Default timing constants match the downstream capture cells' setup windows.
package vec_strobe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int DEF_WIDTH     = 3;
    localparam int DEF_NREQ      = 2;
    localparam int DEF_SETUP_CYC = 10;
    localparam int DEF_PULSE_CYC = 2;
    localparam int DEF_HOLD_CYC  = 1;

    // Wide enough to hold the largest phase length, so the counter never wraps.
    function automatic int cnt_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
        int m;
        m = setup_cyc;
        if (pulse_cyc > m) m = pulse_cyc;
        if (hold_cyc > m)  m = hold_cyc;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: the first active request at or after ptr, circularly.
// Purely combinational; the caller registers the grant and owns the pointer.
module rr_arbiter
    import vec_strobe_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic [NREQ-1:0]              req,
    input  logic                         advance,
    input  logic [idx_width(NREQ)-1:0]   ptr,
    output logic [NREQ-1:0]              grant
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [NREQ-1:0]   pick_rot;
    logic [2*NREQ-1:0] pick_dbl;

    // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_dbl  = {req, req};
        req_rot  = NREQ'(req_dbl >> ptr);
        pick_rot = req_rot & (~req_rot + NREQ'(1));
        pick_dbl = {pick_rot, pick_rot};
        grant    = advance ? NREQ'(pick_dbl << ptr >> NREQ) : '0;
    end

endmodule

// File: rtl/vec_strobe_sequencer.sv
// Shares one data/strobe bus among NREQ requesters: drive data, wait SETUP_CYC,
// strobe the masked lanes for PULSE_CYC, then hold data for HOLD_CYC.
module vec_strobe_sequencer
    import vec_strobe_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int NREQ      = DEF_NREQ,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    input  logic [NREQ*WIDTH-1:0]   req_mask,
    input  logic                    flush,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    aborted,
    output logic                    busy,
    output logic [WIDTH-1:0]        d_out,
    output logic [WIDTH-1:0]        strb_out
);

    localparam int CW        = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int IW        = idx_width(NREQ);
    localparam int HOLD_LOAD = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  d_out_q, d_out_d;
    logic [WIDTH-1:0]  strb_q, strb_d;
    logic [NREQ-1:0]   own_q, own_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              aborted_q, aborted_d;
    logic              busy_q, busy_d;

    logic              arb_advance;
    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     grant_idx;
    logic [WIDTH-1:0]  grant_data;
    logic [WIDTH-1:0]  grant_mask;

    logic [IW-1:0]     idx_chain  [NREQ+1];
    logic [WIDTH-1:0]  data_chain [NREQ+1];
    logic [WIDTH-1:0]  mask_chain [NREQ+1];

    // A flush edge in IDLE must not start a transfer.
    assign arb_advance = (state_q == IDLE) && !flush;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req),
        .advance (arb_advance),
        .ptr     (ptr_q),
        .grant   (arb_grant)
    );

    // Encode the one-hot grant and mux out that requester's data and mask.
    assign idx_chain[0]  = '0;
    assign data_chain[0] = '0;
    assign mask_chain[0] = '0;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel
        assign idx_chain[gi+1]  = idx_chain[gi]  | (arb_grant[gi] ? IW'(gi) : '0);
        assign data_chain[gi+1] = data_chain[gi] | (arb_grant[gi] ? req_data[gi*WIDTH +: WIDTH] : '0);
        assign mask_chain[gi+1] = mask_chain[gi] | (arb_grant[gi] ? req_mask[gi*WIDTH +: WIDTH] : '0);
    end

    assign grant_idx  = idx_chain[NREQ];
    assign grant_data = data_chain[NREQ];
    assign grant_mask = mask_chain[NREQ];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        own_d     = own_q;
        ptr_d     = ptr_q;
        d_out_d   = d_out_q;
        strb_d    = strb_q;
        gnt_d     = '0;
        done_d    = '0;
        aborted_d = 1'b0;

        if (flush && (state_q != IDLE)) begin
            state_d   = IDLE;
            strb_d    = '0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|arb_grant) begin
                        gnt_d   = arb_grant;
                        own_d   = arb_grant;
                        mask_d  = grant_mask;
                        d_out_d = (d_out_q & ~grant_mask) | (grant_data & grant_mask);
                        ptr_d   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
                        cnt_d   = CW'(SETUP_CYC - 1);
                        state_d = SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == '0) begin
                        strb_d  = mask_q;
                        cnt_d   = CW'(PULSE_CYC - 1);
                        state_d = PULSE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                PULSE: begin
                    if (cnt_q == '0) begin
                        strb_d = '0;
                        if (HOLD_CYC == 0) begin
                            done_d  = own_q;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = CW'(HOLD_LOAD);
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        done_d  = own_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mask_q    <= '0;
            own_q     <= '0;
            ptr_q     <= '0;
            d_out_q   <= '0;
            strb_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            own_q     <= own_d;
            ptr_q     <= ptr_d;
            d_out_q   <= d_out_d;
            strb_q    <= strb_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign busy     = busy_q;
    assign d_out    = d_out_q;
    assign strb_out = strb_q;

endmodule
